// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: operand/result stream bundle for cordic_pipe.
// The operand side carries (ix, iy, in_tag) under in_valid/in_ready and the
// result side carries (ox, oy, out_tag) under out_valid/out_ready.
interface cordic_pipe_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W:0]           ix;
  logic [W:0]           iy;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [W+1:0]         ox;
  logic signed [W+2:0]  oy;
  logic [TAG_W-1:0]     out_tag;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, ix, iy, in_tag, out_ready,
    input  in_ready, out_valid, ox, oy, out_tag
  );

  // The CORDIC core.
  modport slave (
    input  in_valid, ix, iy, in_tag, out_ready,
    output in_ready, out_valid, ox, oy, out_tag
  );
endinterface

// File: rtl/cordic_pipe.sv
// cordic_pipe: pipelined CORDIC vectoring engine, one micro-rotation per stage.
//   HYPER=1: x_final ~ K_h * sqrt(ix^2 - iy^2), shifts 1..ITERATION with
//            k = 4, 13, 40 repeated (needed for hyperbolic convergence).
//   HYPER=0: x_final ~ K * sqrt(ix^2 + iy^2), shifts 0..ITERATION-1.
// All stages advance together on adv = ~out_valid | out_ready, so a stalled
// result freezes the whole pipe and nothing is ever dropped or duplicated.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds one output stage that
// multiplies x by the inverse CORDIC gain (UQ.16 constant, truncated).
module cordic_pipe #(
  parameter int W         = 32,
  parameter int ITERATION = 16,
  parameter int HYPER     = 1,
  parameter int TAG_W     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cordic_pipe_if.slave  bus
);

  // Number of pipeline stages including the repeated hyperbolic shifts.
  function automatic int num_stages();
    int n;
    n = ITERATION;
    if (HYPER != 0) begin
      if (ITERATION >= 4)  n = n + 1;
      if (ITERATION >= 13) n = n + 1;
      if (ITERATION >= 40) n = n + 1;
    end else begin
      n = ITERATION;
    end
    return n;
  endfunction

  // Shift index used by pipeline stage idx.
  function automatic int shift_of(input int idx);
    int pos;
    int result;
    result = 0;
    pos    = 0;
    if (HYPER != 0) begin
      for (int k = 1; k <= ITERATION; k++) begin
        if (pos == idx) result = k;
        pos = pos + 1;
        if (k == 4 || k == 13 || k == 40) begin
          if (pos == idx) result = k;
          pos = pos + 1;
        end
      end
    end else begin
      result = idx;
    end
    return result;
  endfunction

  localparam int N  = num_stages();
  localparam int DW = W + 3;

  logic signed [DW-1:0]  x_r    [N];
  logic signed [DW-1:0]  y_r    [N];
  logic [TAG_W-1:0]      tag_r  [N];
  logic [N-1:0]          vld_r;
  logic signed [DW-1:0]  x_in_s [N];
  logic signed [DW-1:0]  y_in_s [N];
  logic signed [DW-1:0]  x_nx_s [N];
  logic signed [DW-1:0]  y_nx_s [N];
  logic                  adv_s;

  assign adv_s        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv_s;

  // Micro-rotation datapath: each stage uses the pre-stage x and y for both updates.
  for (genvar i = 0; i < N; i++) begin : g_iter
    localparam int K = shift_of(i);
    logic signed [DW-1:0] xsh_s;
    logic signed [DW-1:0] ysh_s;
    logic                 neg_s;

    if (i == 0) begin : g_src
      assign x_in_s[i] = {2'b00, bus.ix};
      assign y_in_s[i] = {2'b00, bus.iy};
    end else begin : g_src
      assign x_in_s[i] = x_r[i-1];
      assign y_in_s[i] = y_r[i-1];
    end

    assign xsh_s = x_in_s[i] >>> K;
    assign ysh_s = y_in_s[i] >>> K;
    assign neg_s = y_in_s[i][DW-1];

    if (HYPER != 0) begin : g_mode
      assign x_nx_s[i] = neg_s ? (x_in_s[i] + ysh_s) : (x_in_s[i] - ysh_s);
      assign y_nx_s[i] = neg_s ? (y_in_s[i] + xsh_s) : (y_in_s[i] - xsh_s);
    end else begin : g_mode
      assign x_nx_s[i] = neg_s ? (x_in_s[i] - ysh_s) : (x_in_s[i] + ysh_s);
      assign y_nx_s[i] = neg_s ? (y_in_s[i] + xsh_s) : (y_in_s[i] - xsh_s);
    end
  end

  // Stage register banks: all advance together on adv, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        x_r[i]   <= '0;
        y_r[i]   <= '0;
        tag_r[i] <= '0;
      end
      vld_r <= '0;
    end else if (adv_s) begin
      for (int i = 0; i < N; i++) begin
        x_r[i] <= x_nx_s[i];
        y_r[i] <= y_nx_s[i];
      end
      tag_r[0] <= bus.in_tag;
      vld_r[0] <= bus.in_valid;
      for (int i = 1; i < N; i++) begin
        tag_r[i] <= tag_r[i-1];
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K_h = 1.20750 (UQ1.16) for hyperbolic, 1/K = 0.607253 (UQ0.16) for circular.
  localparam logic [16:0] GAIN_C = (HYPER != 0) ? 17'd79135 : 17'd39797;
  localparam int          PW     = W + 19;

  logic [PW-1:0]        prod_s;
  logic                 gain_unused_s;
  logic [W+1:0]         gox_r;
  logic signed [DW-1:0] goy_r;
  logic [TAG_W-1:0]     gtag_r;
  logic                 gvld_r;

  // Final x is non-negative for valid operands, so its low W+2 bits are the magnitude.
  assign prod_s        = {17'd0, x_r[N-1][W+1:0]} * {{(W+2){1'b0}}, GAIN_C};
  assign gain_unused_s = ^{prod_s[PW-1], prod_s[15:0], x_r[N-1][DW-1]};

  // Gain-compensation stage: same adv enable as the iteration stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gox_r  <= '0;
      goy_r  <= '0;
      gtag_r <= '0;
      gvld_r <= 1'b0;
    end else if (adv_s) begin
      gox_r  <= prod_s[W+17:16];
      goy_r  <= y_r[N-1];
      gtag_r <= tag_r[N-1];
      gvld_r <= vld_r[N-1];
    end
  end

  assign bus.out_valid = gvld_r;
  assign bus.ox        = gox_r;
  assign bus.oy        = goy_r;
  assign bus.out_tag   = gtag_r;
`else
  assign bus.out_valid = vld_r[N-1];
  assign bus.ox        = x_r[N-1][W+1:0];
  assign bus.oy        = y_r[N-1];
  assign bus.out_tag   = tag_r[N-1];
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: self-checking bench for cordic_pipe.
// Two instances (hyperbolic and circular, W=32, ITERATION=16, TAG_W=8) share
// the stimulus; sel_circ chooses which one is driven and observed. Expected
// results come from a real-valued model that applies the micro-rotation rules
// directly, with CORDIC_GAIN_COMP_EN selecting the compensated expectation.
module tb_cordic_pipe;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int GC = 1;
`else
  localparam int GC = 0;
`endif
  localparam int LAT_H = 18 + GC;
  localparam int LAT_C = 16 + GC;

  typedef struct {
    real ex;
    real exr;
    real ey;
    int  tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic        sel_circ;
  logic        tb_in_valid;
  logic        tb_out_ready;
  logic [32:0] tb_ix;
  logic [32:0] tb_iy;
  logic [7:0]  tb_tag;

  cordic_pipe_if #(.W(32), .TAG_W(8)) if_h ();
  cordic_pipe_if #(.W(32), .TAG_W(8)) if_c ();

  cordic_pipe #(.W(32), .ITERATION(16), .HYPER(1), .TAG_W(8)) u_hyp (
    .clk(clk), .rst_n(rst_n), .bus(if_h.slave));
  cordic_pipe #(.W(32), .ITERATION(16), .HYPER(0), .TAG_W(8)) u_circ (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  assign if_h.in_valid  = tb_in_valid & ~sel_circ;
  assign if_c.in_valid  = tb_in_valid & sel_circ;
  assign if_h.out_ready = tb_out_ready | sel_circ;
  assign if_c.out_ready = tb_out_ready | ~sel_circ;
  assign if_h.ix = tb_ix;
  assign if_h.iy = tb_iy;
  assign if_h.in_tag = tb_tag;
  assign if_c.ix = tb_ix;
  assign if_c.iy = tb_iy;
  assign if_c.in_tag = tb_tag;

  logic               obs_in_ready;
  logic               obs_out_valid;
  logic [33:0]        obs_ox;
  logic signed [34:0] obs_oy;
  logic [7:0]         obs_tag;
  assign obs_in_ready  = sel_circ ? if_c.in_ready  : if_h.in_ready;
  assign obs_out_valid = sel_circ ? if_c.out_valid : if_h.out_valid;
  assign obs_ox        = sel_circ ? if_c.ox        : if_h.ox;
  assign obs_oy        = sel_circ ? if_c.oy        : if_h.oy;
  assign obs_tag       = sel_circ ? if_c.out_tag   : if_h.out_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact real-valued micro-rotations following the mode rules.
  function automatic void model(input bit circ, input logic [32:0] a, input logic [32:0] b,
                                output real xo, output real xraw, output real yo);
    real x, y, xn, t;
    int  reps;
    x = real'(a);
    y = real'(b);
    if (circ) begin
      t = 1.0;
      for (int k = 0; k < 16; k++) begin
        if (y < 0.0) begin xn = x - y * t; y = y + x * t; end
        else         begin xn = x + y * t; y = y - x * t; end
        x = xn;
        t = t / 2.0;
      end
    end else begin
      t = 0.5;
      for (int k = 1; k <= 16; k++) begin
        reps = (k == 4 || k == 13) ? 2 : 1;
        for (int r = 0; r < reps; r++) begin
          if (y < 0.0) begin xn = x + y * t; y = y + x * t; end
          else         begin xn = x - y * t; y = y - x * t; end
          x = xn;
        end
        t = t / 2.0;
      end
    end
    xraw = x;
    yo   = y;
`ifdef CORDIC_GAIN_COMP_EN
    xo = $floor(x * (circ ? 39797.0 : 79135.0) / 65536.0);
`else
    xo = x;
`endif
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Send one operand into an idle pipe and capture latency and result.
  task automatic run_one(input bit circ, input logic [32:0] a, input logic [32:0] b,
                         input logic [7:0] t, output int lat, output logic [33:0] rox,
                         output logic signed [34:0] roy, output logic [7:0] rtag);
    sel_circ     = circ;
    tb_out_ready = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b1;
    tb_ix = a;
    tb_iy = b;
    tb_tag = t;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!obs_out_valid) lat = -1;
    rox  = obs_ox;
    roy  = obs_oy;
    rtag = obs_tag;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (if_h.out_valid !== 1'b0) begin bad++; $display("FAIL rst_h_valid got=%b want=0", if_h.out_valid); end
    total++; if (if_h.ox !== 34'd0) begin bad++; $display("FAIL rst_h_ox got=%0d want=0", if_h.ox); end
    total++; if (if_h.oy !== 35'sd0) begin bad++; $display("FAIL rst_h_oy got=%0d want=0", if_h.oy); end
    total++; if (if_h.out_tag !== 8'd0) begin bad++; $display("FAIL rst_h_tag got=%0d want=0", if_h.out_tag); end
    total++; if (if_h.in_ready !== 1'b1) begin bad++; $display("FAIL rst_h_ready got=%b want=1", if_h.in_ready); end
    total++;
    if ({if_c.out_valid, if_c.ox, if_c.oy, if_c.out_tag, if_c.in_ready} !== {1'b0, 34'd0, 35'd0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_c_outputs got=%b/%0d/%0d/%0d/%b want=0/0/0/0/1",
               if_c.out_valid, if_c.ox, if_c.oy, if_c.out_tag, if_c.in_ready);
    end
    rst_n = 1'b1;
  endtask

  // Shared body for the directed single-operand scenarios.
  task automatic check_single(input string nm, input bit circ, input logic [32:0] a,
                              input logic [32:0] b, input logic [7:0] t, input int want_lat);
    int lat; logic [33:0] rox; logic signed [34:0] roy; logic [7:0] rtag;
    real ex, exr, ey, tol;
    model(circ, a, b, ex, exr, ey);
    run_one(circ, a, b, t, lat, rox, roy, rtag);
    tol = ex * 0.0005 + 64.0;
    total++; if (lat !== want_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, want_lat); end
    total++; if (rabs(real'(rox) - ex) > tol) begin bad++; $display("FAIL %s_ox got=%0d want=%0.1f", nm, rox, ex); end
    total++; if (rabs(real'(roy) - ey) > rabs(exr) / 8192.0 + 64.0) begin bad++; $display("FAIL %s_oy got=%0d want=%0.1f", nm, roy, ey); end
    total++; if (rtag !== t) begin bad++; $display("FAIL %s_tag got=%0d want=%0d", nm, rtag, t); end
  endtask

  task automatic test_hyp_sqrt();
    check_single("hyp_sqrt", 1'b0, 33'd278528, 33'd245760, 8'hA5, LAT_H);
  endtask

  task automatic test_circ_mag();
    check_single("circ_mag", 1'b1, 33'd196608, 33'd262144, 8'h3C, LAT_C);
  endtask

  task automatic test_max_input();
    check_single("max_in", 1'b1, 33'h1_FFFF_FFFF, 33'd0, 8'h77, LAT_C);
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int sent, got, cyc;
    bit stalled, acc, ret;
    logic [33:0] h_ox; logic signed [34:0] h_oy; logic [7:0] h_tag;
    logic [32:0] pa, pb;
    sel_circ = 1'b0;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    h_ox = '0; h_oy = '0; h_tag = '0;
    pa = ({1'b0, $urandom()} >> $urandom_range(0, 12)) | 33'h1000;
    pb = {1'b0, $urandom()} % pa;
    while (got < 32 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (obs_out_valid !== 1'b1 || obs_ox !== h_ox || obs_oy !== h_oy || obs_tag !== h_tag) begin
          bad++;
          $display("FAIL b2b_stall_hold got=%b/%0d/%0d/%0d want=1/%0d/%0d/%0d",
                   obs_out_valid, obs_ox, obs_oy, obs_tag, h_ox, h_oy, h_tag);
        end
      end
      tb_out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 32) begin
        tb_in_valid = ($urandom_range(0, 4) != 0);
        tb_ix = pa; tb_iy = pb; tb_tag = 8'(sent);
      end else begin
        tb_in_valid = 1'b0;
      end
      #1;
      acc = tb_in_valid & obs_in_ready;
      ret = obs_out_valid & tb_out_ready;
      if (ret) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=tag %0d want=no result", obs_tag);
        end else begin
          e = q.pop_front();
          if (obs_tag !== 8'(e.tag)) begin bad++; $display("FAIL b2b_tag got=%0d want=%0d", obs_tag, e.tag); end
          total++;
          if (rabs(real'(obs_ox) - e.ex) > e.ex * 0.0005 + 64.0) begin
            bad++; $display("FAIL b2b_ox tag=%0d got=%0d want=%0.1f", e.tag, obs_ox, e.ex);
          end
          total++;
          if (rabs(real'(obs_oy) - e.ey) > rabs(e.exr) / 8192.0 + 64.0) begin
            bad++; $display("FAIL b2b_oy tag=%0d got=%0d want=%0.1f", e.tag, obs_oy, e.ey);
          end
        end
        got++;
      end
      stalled = obs_out_valid & ~tb_out_ready;
      h_ox = obs_ox; h_oy = obs_oy; h_tag = obs_tag;
      if (acc) begin
        model(1'b0, pa, pb, e.ex, e.exr, e.ey);
        e.tag = sent;
        q.push_back(e);
        sent++;
        pa = ({1'b0, $urandom()} >> $urandom_range(0, 12)) | 33'h1000;
        pb = {1'b0, $urandom()} % pa;
      end
    end
    total++; if (got != 32 || q.size() != 0) begin bad++; $display("FAIL b2b_count got=%0d left=%0d want=32 left=0", got, q.size()); end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    repeat (LAT_H + 2) @(negedge clk);
  endtask

  task automatic test_midflight_reset();
    int stale;
    sel_circ = 1'b0;
    tb_out_ready = 1'b0;
    for (int i = 0; i < LAT_H + 4; i++) begin
      @(negedge clk);
      tb_in_valid = 1'b1;
      tb_ix = ({1'b0, $urandom()} >> 4) | 33'h10000;
      tb_iy = tb_ix >> 2;
      tb_tag = 8'(8'h40 + i);
    end
    @(negedge clk);
    tb_in_valid = 1'b0;
    total++; if (obs_out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_prefill got=%b want=1", obs_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", obs_out_valid); end
    total++; if (obs_ox !== 34'd0 || obs_oy !== 35'sd0) begin bad++; $display("FAIL rstmid_data got=%0d/%0d want=0/0", obs_ox, obs_oy); end
    total++; if (obs_tag !== 8'd0) begin bad++; $display("FAIL rstmid_tag got=%0d want=0", obs_tag); end
    total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", obs_in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tb_out_ready = 1'b1;
    stale = 0;
    repeat (2 * LAT_H) begin
      @(negedge clk);
      if (obs_out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rstmid_stale got=%0d want=0", stale); end
    check_single("rstmid_new", 1'b0, 33'd3000000, 33'd1000000, 8'h99, LAT_H);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    sel_circ = 1'b0;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    tb_ix = '0;
    tb_iy = '0;
    tb_tag = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_hyp_sqrt();
    test_circ_mag();
    test_max_input();
    test_back_to_back();
    test_midflight_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
